// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: loads the PC-1 output and emits the rotated C||D pair once per round.
// Optional reverse (decrypt) ordering is built only when DES_KS_DECRYPT_EN is defined.
module des_key_schedule #(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [55:0] key_in,
  input  logic        decrypt,
  input  logic        ready_in,
  output logic        valid,
  output logic [55:0] cd_out,
  output logic [3:0]  round,
  output logic        last,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

  logic [1:0]  state_q, state_d;
  logic        valid_q, valid_d;
  logic [3:0]  round_q, round_d;
  logic [55:0] cd_q, cd_d;

  // Standard DES shift table: single shifts at rounds 0, 1, 8 and 15, double elsewhere.
  function automatic logic [1:0] shamt(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd8, 4'd15: shamt = 2'd1;
      default:                 shamt = 2'd2;
    endcase
  endfunction

  // Each 28-bit half wraps on itself; no bits move between C and D.
  function automatic logic [55:0] rotl_cd(input logic [55:0] cd, input logic [1:0] n);
    logic [27:0] c, d;
    c = cd[55:28];
    d = cd[27:0];
    if (n == 2'd1) rotl_cd = {c[26:0], c[27], d[26:0], d[27]};
    else           rotl_cd = {c[25:0], c[27:26], d[25:0], d[27:26]};
  endfunction

`ifdef DES_KS_DECRYPT_EN
  logic dec_q, dec_d;

  function automatic logic [55:0] rotr_cd(input logic [55:0] cd, input logic [1:0] n);
    logic [27:0] c, d;
    c = cd[55:28];
    d = cd[27:0];
    if (n == 2'd1) rotr_cd = {c[0], c[27:1], d[0], d[27:1]};
    else           rotr_cd = {c[1:0], c[27:2], d[1:0], d[27:2]};
  endfunction
`else
  logic unused_decrypt;
  assign unused_decrypt = decrypt;
`endif

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    round_d = round_q;
    cd_d    = cd_q;
`ifdef DES_KS_DECRYPT_EN
    dec_d   = dec_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ROUND;
          valid_d = 1'b1;
          round_d = 4'd0;
`ifdef DES_KS_DECRYPT_EN
          dec_d   = decrypt;
          // Decrypt starts from K16, whose cumulative shift of 28 is the identity.
          cd_d    = decrypt ? key_in : rotl_cd(key_in, shamt(4'd0));
`else
          cd_d    = rotl_cd(key_in, shamt(4'd0));
`endif
        end
      end
      S_ROUND: begin
        if (valid_q && ready_in) begin
          if (round_q == LAST_RND) begin
            valid_d = 1'b0;
            state_d = S_DONE;
          end else begin
            round_d = round_q + 4'd1;
`ifdef DES_KS_DECRYPT_EN
            cd_d    = dec_q ? rotr_cd(cd_q, shamt(4'd15 - round_q))
                            : rotl_cd(cd_q, shamt(round_q + 4'd1));
`else
            cd_d    = rotl_cd(cd_q, shamt(round_q + 4'd1));
`endif
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      round_q <= 4'd0;
      cd_q    <= 56'd0;
`ifdef DES_KS_DECRYPT_EN
      dec_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      round_q <= round_d;
      cd_q    <= cd_d;
`ifdef DES_KS_DECRYPT_EN
      dec_q   <= dec_d;
`endif
    end
  end

  assign valid  = valid_q;
  assign cd_out = cd_q;
  assign round  = round_q;
  assign last   = valid_q && (round_q == LAST_RND);
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: cumulative-shift reference model plus directed runs
// (encrypt, backpressure, start while busy, mid-run reset, decrypt request).
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst, start, decrypt, ready_in;
  logic [55:0] key_in;
  logic        valid, last, busy, done;
  logic [55:0] cd_out;
  logic [3:0]  round;

  des_key_schedule #(.ROUNDS(16)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .decrypt(decrypt),
    .ready_in(ready_in), .valid(valid), .cd_out(cd_out), .round(round),
    .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

`ifdef DES_KS_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  localparam logic [55:0] KEY  = 56'hF0CCAAF556678F;
  localparam logic [55:0] KEY2 = 56'h123456789ABCDE;
  localparam logic [55:0] K1   = 56'hE19955FAACCF1E;
  localparam logic [55:0] K2   = 56'hC332ABF5599E3D;
  localparam logic [55:0] DK2  = 56'hF866557AAB33C7;

  int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] rot28(input logic [27:0] x, input int s);
    logic [55:0] t;
    t = {x, x} << s;
    return t[55:28];
  endfunction

  // Round r subkey pair = key rotated by the cumulative shift through round r
  // (decrypt order reads the encrypt list backwards).
  function automatic logic [55:0] sched(input logic [55:0] k, input bit dec, input int r);
    int idx, s;
    idx = dec ? 15 - r : r;
    s = 0;
    for (int i = 0; i <= idx; i++) s += SH[i];
    s = s % 28;
    return {rot28(k[55:28], s), rot28(k[27:0], s)};
  endfunction

  // Reference model of the transaction-level behaviour.
  int          m_st  = 0;
  int          m_rnd = 0;
  bit          m_dec = 1'b0;
  bit          m_clr = 1'b0;
  logic [55:0] m_key = '0;
  int          dut_xfers = 0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_st  <= 0;
      m_rnd <= 0;
      m_clr <= 1'b1;
    end else begin
      case (m_st)
        0: if (start) begin
          m_st  <= 1;
          m_rnd <= 0;
          m_key <= key_in;
          m_dec <= DEC_EN && decrypt;
          m_clr <= 1'b0;
        end
        1: if (ready_in) begin
          if (m_rnd == 15) m_st <= 2;
          else             m_rnd <= m_rnd + 1;
        end
        default: m_st <= 0;
      endcase
    end
  end

  always @(posedge clk)
    if (!rst && valid && ready_in) dut_xfers <= dut_xfers + 1;

  always @(negedge clk) begin
    bit ev;
    if (chk_en) begin
      ev = (m_st == 1);
      chk("valid", 64'(valid), 64'(ev));
      chk("busy",  64'(busy),  64'(m_st != 0));
      chk("done",  64'(done),  64'(m_st == 2));
      chk("last",  64'(last),  64'(ev && m_rnd == 15));
      if (ev) begin
        chk("round",  64'(round),  64'(m_rnd));
        chk("cd_out", 64'(cd_out), 64'(sched(m_key, m_dec, m_rnd)));
      end
      if (m_clr) begin
        chk("idle_round", 64'(round),  64'd0);
        chk("idle_cd",    64'(cd_out), 64'd0);
      end
    end
  end

  task automatic run(input logic [55:0] k, input bit dec, input int bp_rnd, input int bp_len,
                     input int bs_rnd, input int rs_rnd, input string tag);
    int n, bp_cnt, base;
    bit got_done, did_bs, s0, s1, s15, rdec;
    logic [55:0] held, e0, e1, e15;
    rdec = dec && DEC_EN;
    e0  = rdec ? KEY : K1;
    e1  = rdec ? DK2 : K2;
    e15 = rdec ? K1  : KEY;
    n = 0; bp_cnt = 0; got_done = 0; did_bs = 0; s0 = 0; s1 = 0; s15 = 0; held = '0;
    @(negedge clk);
    key_in = k; decrypt = dec; start = 1'b1; ready_in = 1'b1;
    base = dut_xfers;
    @(negedge clk);
    start = 1'b0; key_in = KEY2; n = 1;
    while (n < 80 && !got_done) begin
      if (done) begin
        got_done = 1'b1;
      end else begin
        start = 1'b0; ready_in = 1'b1;
        if (valid) begin
          if (round == 4'd0 && !s0) begin chk({tag, "_r0"}, 64'(cd_out), 64'(e0)); s0 = 1; end
          if (round == 4'd1 && !s1) begin chk({tag, "_r1"}, 64'(cd_out), 64'(e1)); s1 = 1; end
          if (round == 4'd15 && !s15) begin
            chk({tag, "_r15"}, 64'(cd_out), 64'(e15));
            chk({tag, "_last"}, 64'(last), 64'd1);
            s15 = 1;
          end
          if (int'(round) == bs_rnd && !did_bs) begin
            start = 1'b1; did_bs = 1'b1;
          end
          if (int'(round) == bp_rnd && bp_cnt <= bp_len) begin
            if (bp_cnt == 0) held = cd_out;
            else             chk({tag, "_bp_hold"}, 64'(cd_out), 64'(held));
            if (bp_cnt < bp_len) ready_in = 1'b0;
            bp_cnt++;
          end
          if (int'(round) == rs_rnd) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk({tag, "_rst_valid"}, 64'(valid),  64'd0);
            chk({tag, "_rst_busy"},  64'(busy),   64'd0);
            chk({tag, "_rst_done"},  64'(done),   64'd0);
            chk({tag, "_rst_cd"},    64'(cd_out), 64'd0);
            chk({tag, "_rst_round"}, 64'(round),  64'd0);
            repeat (20) begin
              @(negedge clk);
              chk({tag, "_no_done"}, 64'(done), 64'd0);
            end
            return;
          end
        end
        @(negedge clk);
        n++;
      end
    end
    chk({tag, "_done_seen"}, 64'(got_done), 64'd1);
    if (got_done) begin
      chk({tag, "_latency"}, 64'(n), 64'(17 + bp_len));
      chk({tag, "_xfers"}, 64'(dut_xfers - base), 64'd16);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; decrypt = 1'b0; ready_in = 1'b1; key_in = '0;

    chk("model_enc_r0",  64'(sched(KEY, 1'b0, 0)),  64'(K1));
    chk("model_enc_r1",  64'(sched(KEY, 1'b0, 1)),  64'(K2));
    chk("model_enc_r15", 64'(sched(KEY, 1'b0, 15)), 64'(KEY));
    chk("model_dec_r0",  64'(sched(KEY, 1'b1, 0)),  64'(KEY));
    chk("model_dec_r1",  64'(sched(KEY, 1'b1, 1)),  64'(DK2));
    chk("model_dec_r15", 64'(sched(KEY, 1'b1, 15)), 64'(K1));

    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_valid", 64'(valid),  64'd0);
    chk("reset_busy",  64'(busy),   64'd0);
    chk("reset_done",  64'(done),   64'd0);
    chk("reset_last",  64'(last),   64'd0);
    chk("reset_round", 64'(round),  64'd0);
    chk("reset_cd",    64'(cd_out), 64'd0);
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;

    run(KEY, 1'b0, -1, 0, -1, -1, "enc");
    run(KEY, 1'b0,  4, 3, -1, -1, "bp");
    run(KEY, 1'b0, -1, 0,  6, -1, "busy_start");
    run(KEY, 1'b0, -1, 0, -1,  7, "midrst");
    run(KEY, 1'b0, -1, 0, -1, -1, "after_rst");
    run(KEY, 1'b1, -1, 0, -1, -1, "dec");

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

- Iterative DES key-schedule generator.
- Accepts the 56-bit PC-1 output, then produces the rotated C‖D register once per round for 16 rounds (one per valid/ready transfer).
- Sits between the PC-1 permutation stage (upstream) and the PC-2 permutation stage (downstream); `cd_out` feeds PC-2 directly.
- Each round's subkey is therefore available to the round datapath one transfer at a time.

## Interface
Parameters:
- `ROUNDS`, 16: number of subkeys generated. Shift schedule is indexed 0..ROUNDS-1 from the standard table. Values other than 16 are for test only; decrypt requires 16.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  load `key_in` and begin a schedule; honoured only in IDLE.
- `key_in`  in  56  PC-1 output. C = `key_in[55:28]`, D = `key_in[27:0]`.
- `decrypt`  in  1  direction, sampled with `start`. Used only when `DES_KS_DECRYPT_EN` is defined.
- `ready_in`  in  1  downstream accepts `cd_out` this cycle.
- `valid`  out  1  `cd_out` and `round` are valid.
- `cd_out`  out  56  rotated {C,D} for the current round.
- `round`  out  4  current round index, 0..ROUNDS-1.
- `last`  out  1  `valid && round == ROUNDS-1`.
- `busy`  out  1  high in ROUND and DONE.
- `done`  out  1  one-cycle pulse after the final transfer.

## Operation
- Shift table `SH[0..15]` = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. The sum is 28, so after 16 rounds C‖D returns to the loaded value.
- Rotation is applied independently to each 28-bit half, with circular wrap within the half. No bits cross between C and D.
- State machine:
  - IDLE:
    - On `start`: `round` <= 0, `valid` <= 1, go to ROUND.
    - Encrypt: `cd_out` <= rotl(`key_in`, SH[0]).
    - Decrypt: `cd_out` <= `key_in` unrotated.
  - ROUND:
    - Transfer = `valid && ready_in`.
    - On a transfer with `round == ROUNDS-1`: `valid` <= 0, go to DONE.
    - On any other transfer, `round` increments and `cd_out` updates:
      - Encrypt: `cd_out` <= rotl(`cd_out`, SH[round+1]).
      - Decrypt: `cd_out` <= rotr(`cd_out`, SH[15-round]).
    - With no transfer, all outputs hold.
  - DONE: `done` = 1 for exactly one cycle, then go to IDLE.
- `start` is ignored in ROUND and DONE; the in-flight schedule is unaffected. `key_in` is not re-sampled.
- `rst` in any state wins over `start` and `ready_in` in the same cycle.

## Timing
- Reset values (visible after the first clock edge with `rst` = 1):
  - State IDLE.
  - `valid`, `busy`, `done`, `last` = 0.
  - `round` = 0, `cd_out` = 0.
- Latency:
  - `start` (IDLE) -> `valid` = 1 with round 0 on the next cycle.
  - With `ready_in` held high: one round per cycle, 16 transfers, `done` in the cycle after the last transfer, IDLE the cycle after that.
  - `start` to `done` = 17 cycles; next `start` is accepted at cycle 18.
- Backpressure: `cd_out`, `round` and `last` are stable while `valid && !ready_in`. No transfer is lost or duplicated.
- Reset mid-schedule: abort. Outputs take reset values at the next edge, and no `done` pulse is produced.
- `ready_in` is don't-care when `valid` = 0.

## Configuration
- `DES_KS_DECRYPT_EN` defined:
  - `decrypt` is sampled with `start`.
  - `decrypt` = 1 produces the schedule in reverse order: K16 first, K1 last.
- `DES_KS_DECRYPT_EN` undefined:
  - Decrypt rotation logic is not built and the `decrypt` port is ignored; it is kept for interface stability and is tied 0 by integrators.
  - The block always produces the encrypt order.

## Test plan
- Encrypt sequence: reset, then `start` with `key_in` = 56'hF0CCAAF556678F, `ready_in` = 1. Required:
  - Round 0 `cd_out` = 56'hE19955FAACCF1E.
  - Round 1 `cd_out` = 56'hC332ABF5599E3D.
  - Round 15 `cd_out` = 56'hF0CCAAF556678F with `last` = 1.
  - `done` pulses 17 cycles after `start`.
- Backpressure: same key, `ready_in` low for 3 cycles while `round` = 4. Required: `cd_out`/`round` unchanged for those cycles; the sequence resumes with round 5 correct; total transfers = 16.
- Start while busy: pulse `start` with a different `key_in` during round 6. Required: the sequence is unchanged and completes to the original round-15 value.
- Mid-run reset: assert `rst` at round 7. Required: next cycle `valid`/`busy`/`done` = 0 and `cd_out` = 0, with no `done` pulse. A following `start` reproduces the encrypt sequence from round 0.
- Decrypt with `DES_KS_DECRYPT_EN` defined, `decrypt` = 1, same key. Required:
  - Round 0 `cd_out` = 56'hF0CCAAF556678F.
  - Round 1 `cd_out` = 56'hF866557AAB33C7.
  - Round 15 `cd_out` = 56'hE19955FAACCF1E.
- Decrypt with the macro undefined: `decrypt` = 1 with the same key. Required: output is identical to the encrypt sequence.
